// File: rtl/io_sw_debounce.sv
// io_sw_debounce: synchronises raw slide switches and debounces each bit for the MEM stage.
// Optional build macro SW_EDGE_LATCH_EN adds sticky rising-edge latches (sw_event, evt_clr).
module io_sw_debounce #(
    parameter int N_SW        = 10,
    parameter int DB_CYCLES   = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N_SW-1:0] sw_raw,
`ifdef SW_EDGE_LATCH_EN
    input  logic            evt_clr,
    output logic [N_SW-1:0] sw_event,
`endif
    output logic [N_SW-1:0] io_in_sw,
    output logic            sw_changed,
    output logic            sw_valid
);

    localparam int               CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_SW-1:0]  sync_q [SYNC_STAGES];
    logic [N_SW-1:0]  sync_s;
    logic [CNT_W-1:0] cnt_q  [N_SW];
    logic [CNT_W-1:0] cnt_d  [N_SW];
    logic [N_SW-1:0]  deb_q;
    logic [N_SW-1:0]  deb_d;
    logic             sw_changed_q;
    logic             sw_changed_d;

    // Metastability chain; only the last stage is ever looked at.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any agreement between the synchronised and accepted level restarts that bit's count,
    // so the counter can never run past CNT_MAX.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign sw_changed_d = |(deb_d ^ deb_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q        <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q        <= deb_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign io_in_sw   = deb_q;
    assign sw_changed = sw_changed_q;
    assign sw_valid   = (sync_s == deb_q);

`ifdef SW_EDGE_LATCH_EN
    logic [N_SW-1:0] evt_q;
    logic [N_SW-1:0] evt_d;

    // A rise on the same edge as a clear must survive, so the set term is ORed in last.
    always_comb begin
        evt_d = evt_clr ? '0 : evt_q;
        evt_d = evt_d | (deb_d & ~deb_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign sw_event = evt_q;
`endif

endmodule

// File: tb/tb_io_sw_debounce.sv
// tb_io_sw_debounce: directed and random stimulus for io_sw_debounce, checked every cycle against
// a history-window reference model (a bit flips once its last DB_CYCLES synchronised samples all differ).
module tb_io_sw_debounce;
   localparam int N_SW        = 10;
   localparam int DB_CYCLES   = 4;
   localparam int SYNC_STAGES = 2;

   logic            clock = 1'b0;
   logic            resetn;
   logic [N_SW-1:0] sw_raw;
   logic [N_SW-1:0] io_in_sw;
   logic            sw_changed;
   logic            sw_valid;
`ifdef SW_EDGE_LATCH_EN
   logic            evt_clr;
   logic [N_SW-1:0] sw_event;
`endif

   int checks = 0;
   int errors = 0;

   logic [N_SW-1:0] rawHist[$];
   logic [N_SW-1:0] mDeb;
   logic [N_SW-1:0] mEvt;
   logic            mChanged;

   io_sw_debounce #(
      .N_SW       (N_SW),
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .sw_raw    (sw_raw),
`ifdef SW_EDGE_LATCH_EN
      .evt_clr   (evt_clr),
      .sw_event  (sw_event),
`endif
      .io_in_sw  (io_in_sw),
      .sw_changed(sw_changed),
      .sw_valid  (sw_valid)
   );

   always #5 clock = ~clock;

   // Raw sample taken at edge number idx+1 since reset; before reset everything reads 0.
   function automatic logic [N_SW-1:0] histAt(input int idx);
      if (idx < 0 || idx >= rawHist.size()) return '0;
      return rawHist[idx];
   endfunction

   function automatic logic [N_SW-1:0] modelSync();
      return histAt(rawHist.size() - SYNC_STAGES);
   endfunction

   // Clears the model the way a reset clears the design.
   task automatic modelReset();
      rawHist.delete();
      mDeb     = '0;
      mEvt     = '0;
      mChanged = 1'b0;
   endtask

   // Advances the model by one rising edge on which raw/clr were sampled.
   task automatic modelEdge(input logic [N_SW-1:0] raw, input logic clr);
      int              n;
      logic [N_SW-1:0] newDeb;
      logic [N_SW-1:0] sample;
      logic            allDiffer;
      n      = rawHist.size();
      newDeb = mDeb;
      for (int b = 0; b < N_SW; b++) begin
         allDiffer = 1'b1;
         for (int k = n - SYNC_STAGES - DB_CYCLES + 1; k <= n - SYNC_STAGES; k++) begin
            sample = histAt(k);
            if (sample[b] == mDeb[b]) allDiffer = 1'b0;
         end
         if (allDiffer) newDeb[b] = ~mDeb[b];
      end
      mEvt     = (clr ? '0 : mEvt) | (newDeb & ~mDeb);
      mChanged = (newDeb != mDeb);
      mDeb     = newDeb;
      rawHist.push_back(raw);
   endtask

   task automatic checkEq(input string tag, input logic [N_SW-1:0] obs, input logic [N_SW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkEq("model_io_in_sw", io_in_sw, mDeb);
      checkBit("model_sw_changed", sw_changed, mChanged);
      checkBit("model_sw_valid", sw_valid, modelSync() == mDeb);
`ifdef SW_EDGE_LATCH_EN
      checkEq("model_sw_event", sw_event, mEvt);
`endif
   endtask

   // Drive inputs after a falling edge, let one rising edge sample them, compare on the next falling edge.
   task automatic applyStimulus(input logic [N_SW-1:0] raw, input logic clr);
      sw_raw = raw;
`ifdef SW_EDGE_LATCH_EN
      evt_clr = clr;
`endif
      @(posedge clock);
      modelEdge(raw, clr);
      @(negedge clock);
      checkOutput();
   endtask

   task automatic resetDut(input logic [N_SW-1:0] raw);
      sw_raw = raw;
      resetn = 1'b0;
      modelReset();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   logic [N_SW-1:0] vec;
   int              len;

   initial begin
      resetn = 1'b0;
      sw_raw = '1;
`ifdef SW_EDGE_LATCH_EN
      evt_clr = 1'b0;
`endif
      modelReset();
      repeat (2) @(negedge clock);
      checkEq("reset_io_in_sw", io_in_sw, '0);
      checkBit("reset_sw_changed", sw_changed, 1'b0);
      checkBit("reset_sw_valid", sw_valid, 1'b1);
`ifdef SW_EDGE_LATCH_EN
      checkEq("reset_sw_event", sw_event, '0);
`endif
      resetn = 1'b1;

      // All switches high out of reset: accepted on the 6th edge.
      for (int c = 1; c <= 8; c++) begin
         applyStimulus('1, 1'b0);
         checkEq("plan_allhigh_io", io_in_sw, (c >= 6) ? '1 : '0);
         checkBit("plan_allhigh_chg", sw_changed, c == 6);
      end

      // A 3-cycle pulse never gets through.
      resetDut('0);
      repeat (3) applyStimulus('0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         applyStimulus((c <= 3) ? 10'h001 : 10'h000, 1'b0);
         checkEq("plan_pulse_io", io_in_sw, '0);
         checkBit("plan_pulse_chg", sw_changed, 1'b0);
      end

      // Bit 5 bounces 1,0,1 then holds: accepted 6 edges after the final transition.
      for (int c = 1; c <= 10; c++) begin
         applyStimulus((c == 2) ? 10'h000 : 10'h020, 1'b0);
         checkBit("plan_bounce_b5", io_in_sw[5], c >= 8);
      end

      // Bit 3 then bit 7 two cycles later: two separate updates and strobes.
      resetDut('0);
      repeat (3) applyStimulus('0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         applyStimulus((c <= 2) ? 10'h008 : 10'h088, 1'b0);
         checkEq("plan_stagger_io", io_in_sw,
                 (c >= 8) ? 10'h088 : ((c >= 6) ? 10'h008 : 10'h000));
         checkBit("plan_stagger_chg", sw_changed, (c == 6) || (c == 8));
      end

      // Reset mid-count right after an update: outputs clear without a clock edge.
      resetDut('0);
      repeat (3) applyStimulus('0, 1'b0);
      for (int c = 1; c <= 6; c++) applyStimulus((c <= 2) ? 10'h0FF : 10'h3FF, 1'b0);
      checkEq("plan_pre_reset_io", io_in_sw, 10'h0FF);
      #2;
      resetn = 1'b0;
      #1;
      checkEq("plan_async_reset_io", io_in_sw, '0);
      checkBit("plan_async_reset_chg", sw_changed, 1'b0);
      modelReset();
      @(negedge clock);
      resetn = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(10'h3FF, 1'b0);
         checkEq("plan_requalify_io", io_in_sw, (c >= 6) ? 10'h3FF : 10'h000);
      end

`ifdef SW_EDGE_LATCH_EN
      // Sticky rise latch; a clear on the same edge as a new rise keeps the new rise.
      resetDut('0);
      repeat (3) applyStimulus('0, 1'b0);
      for (int c = 1; c <= 8; c++) applyStimulus(10'h004, 1'b0);
      checkEq("plan_evt_set", sw_event, 10'h004);
      for (int c = 1; c <= 5; c++) applyStimulus(10'h204, 1'b0);
      checkEq("plan_evt_held", sw_event, 10'h004);
      applyStimulus(10'h204, 1'b1);
      checkEq("plan_evt_clr_vs_set", sw_event, 10'h200);
      applyStimulus(10'h204, 1'b0);
      checkEq("plan_evt_hold2", sw_event, 10'h200);
      applyStimulus(10'h204, 1'b1);
      checkEq("plan_evt_clear", sw_event, 10'h000);
`endif

      // Random segments of varying hold length, mixing short glitches with long holds.
      resetDut('0);
      vec = '0;
      for (int seg = 0; seg < 90; seg++) begin
         len = int'($urandom_range(1, 9));
         vec = vec ^ (N_SW'($urandom) & N_SW'($urandom));
         for (int c = 0; c < len; c++) begin
            applyStimulus(vec, $urandom_range(0, 7) == 0);
         end
      end
      for (int c = 0; c < 8; c++) applyStimulus(vec, 1'b0);
      checkEq("random_settled_io", io_in_sw, vec);
      checkBit("random_settled_valid", sw_valid, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_sw_debounce.md
Name: io_sw_debounce

Overview:
- Input-conditioning stage directly upstream of the memory/IO stage; drives its io_in_sw switch bus.
- Synchronises the raw board slide-switches into the CPU clock domain and debounces each bit independently.
- The MEM stage reads only a clean, stable switch word, plus a change strobe and a settled flag.

Parameters:
- N_SW, 10, number of switch bits.
- DB_CYCLES, 50000, consecutive stable cycles required before a bit is accepted; legal range >= 1.
- SYNC_STAGES, 2, depth of the per-bit synchroniser flop chain; legal range >= 2.

Ports:
- clock  in  1  CPU clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sw_raw  in  N_SW  raw, asynchronous switch levels from the pins.
- io_in_sw  out  N_SW  debounced switch word, registered; feeds the MEM stage.
- sw_changed  out  1  one-cycle strobe: io_in_sw updated on this edge.
- sw_valid  out  1  high when every synchronised bit equals its debounced bit (no debounce in progress).

Behaviour:
- Reset: resetn low clears immediately (asynchronous) all of the following to 0:
  - synchroniser flops, per-bit counters, io_in_sw, sw_changed.
  - sw_valid then reads 1, because the synchronised value and the debounced value are both 0.
- Synchroniser: s[i] is the output of a SYNC_STAGES-deep flop chain on sw_raw[i]. No combinational path from sw_raw to any output.
- Per-bit counter cnt[i], width clog2(DB_CYCLES) (minimum 1). Each edge:
  - s[i] == io_in_sw[i]: cnt[i] <= 0. A glitch or bounce restarts the count.
  - s[i] != io_in_sw[i] and cnt[i] == DB_CYCLES-1: io_in_sw[i] <= s[i], cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i] + 1.
- Latency: a raw level held stable appears on io_in_sw exactly SYNC_STAGES + DB_CYCLES rising edges after the first edge that samples it.
- A pulse shorter than DB_CYCLES cycles at the synchroniser output never propagates.
- Bits are fully independent:
  - Simultaneous qualifying bits update on the same edge.
  - Unrelated bits never disturb each other's counters.
- sw_changed is registered and is high for the cycle following any edge on which at least one io_in_sw bit changed.
  - Back-to-back updates on consecutive edges keep it high for consecutive cycles.
- sw_valid is combinational: (s == io_in_sw).
- Counter never wraps; it saturates by construction at DB_CYCLES-1.
- Reset asserted mid-count discards all pending counts. After release, switches held at 1 re-qualify with full latency.

Optional Feature:
- Macro: SW_EDGE_LATCH_EN.
- When defined, the block adds:
  - input evt_clr (1 bit).
  - output sw_event (N_SW bits): sticky per-bit latch, set on the edge where io_in_sw[i] rises 0->1.
  - evt_clr high clears all latches on the next edge.
  - If a rise and evt_clr occur on the same edge, set wins for that bit.
  - sw_event resets to 0.
- When undefined: neither port exists and no latch logic is generated.

Test Plan (DB_CYCLES=4, SYNC_STAGES=2):
- Reset released with sw_raw=10'h3FF -> io_in_sw=0 for 5 edges, 10'h3FF after the 6th edge; sw_changed high exactly 1 cycle; sw_valid low during the count, then 1.
- sw_raw[0] pulsed high for 3 cycles -> io_in_sw stays 10'h000, sw_changed never asserts.
- sw_raw[5] bounces 1,0,1 on consecutive cycles, then holds 1 -> io_in_sw[5]=1 exactly 6 edges after the last transition.
- sw_raw[3] rises, sw_raw[7] rises 2 cycles later -> io_in_sw goes 10'h008, then 10'h088 two cycles later; two separate sw_changed pulses.
- resetn pulled low mid-count with io_in_sw=10'h0FF -> io_in_sw=0 and sw_changed=0 immediately, without waiting for a clock edge.
- SW_EDGE_LATCH_EN: sw_raw[2] rises -> sw_event=10'h004 held until evt_clr. evt_clr on the same edge as the io_in_sw[9] rise -> sw_event=10'h200.
